// File: rtl/rank_filter3x3_if.sv
// rtl/rank_filter3x3_if.sv - pixel stream in/out bundle for the 3x3 rank filter
interface rank_filter3x3_if #(
  parameter int DATA_W = 8
);
  logic              per_frame_vsync;
  logic              per_frame_href;
  logic              per_frame_clken;
  logic [DATA_W-1:0] per_data;
  logic [1:0]        mode;
  logic              post_frame_vsync;
  logic              post_frame_href;
  logic              post_frame_clken;
  logic [DATA_W-1:0] post_data;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_data, mode,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_data
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_data, mode,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_data
  );
endinterface

// File: rtl/rank_filter3x3.sv
// rtl/rank_filter3x3.sv - 3x3 median/min/max rank filter on a pixel stream
// Window capture plus three pipeline stages; sync signals delayed to match.
module rank_filter3x3 #(
  parameter int DATA_W    = 8,
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int CNT_W     = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  rank_filter3x3_if.slave px
);

  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_HDISP - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_VDISP - 1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? b : a;
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return min2(min2(a, b), c);
  endfunction

  function automatic logic [DATA_W-1:0] mid3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic              vsync_prev_q, href_prev_q;
  logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        fmode_q, fmode_d, sel_q, sel_d;
  logic              acc, vs_rise, hr_fall, cplt;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] lb1_q [IMG_HDISP];
  logic [DATA_W-1:0] lb2_q [IMG_HDISP];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] s1_max_q [3];
  logic [DATA_W-1:0] s1_mid_q [3];
  logic [DATA_W-1:0] s1_min_q [3];
  logic [DATA_W-1:0] s1_ctr_q;
  logic [1:0]        s1_sel_q;
  logic [DATA_W-1:0] s2_lo_q, s2_md_q, s2_hi_q, s2_gmin_q, s2_gmax_q, s2_ctr_q;
  logic [1:0]        s2_sel_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        vs_dly_q, hr_dly_q, ck_dly_q;

  // ovf_q marks that column IMG_HDISP-1 was consumed; later pixels on the line are dropped.
  assign acc     = px.per_frame_clken & px.per_frame_href & ~ovf_q;
  assign vs_rise = px.per_frame_vsync & ~vsync_prev_q;
  assign hr_fall = ~px.per_frame_href & href_prev_q;
  assign addr    = col_q[AW-1:0];
  assign lb1_rd  = lb1_q[addr];
  assign lb2_rd  = lb2_q[addr];

  always_comb begin
    col_d   = col_q;
    ovf_d   = ovf_q;
    row_d   = row_q;
    fmode_d = fmode_q;
    if (hr_fall) begin
      col_d = '0;
      ovf_d = 1'b0;
    end else if (acc) begin
      if (col_q == COL_LAST) ovf_d = 1'b1;
      else                   col_d = col_q + CNT_W'(1);
    end
    if (vs_rise)                             row_d = '0;
    else if (hr_fall && (row_q != ROW_LAST)) row_d = row_q + CNT_W'(1);
    if (vs_rise) fmode_d = px.mode;
    cplt  = acc && (col_q >= TWO) && (row_q >= TWO);
    sel_d = cplt ? fmode_q : 2'd3;
  end

  // Line buffers carry no reset: incomplete windows never expose their stale words.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1_q[addr] <= px.per_data;
      lb2_q[addr] <= lb1_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      ovf_q        <= 1'b0;
      fmode_q      <= 2'd0;
      sel_q        <= 2'd0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
        s1_max_q[r] <= '0;
        s1_mid_q[r] <= '0;
        s1_min_q[r] <= '0;
      end
      s1_ctr_q  <= '0;
      s1_sel_q  <= 2'd0;
      s2_lo_q   <= '0;
      s2_md_q   <= '0;
      s2_hi_q   <= '0;
      s2_gmin_q <= '0;
      s2_gmax_q <= '0;
      s2_ctr_q  <= '0;
      s2_sel_q  <= 2'd0;
      data_q    <= '0;
      vs_dly_q  <= '0;
      hr_dly_q  <= '0;
      ck_dly_q  <= '0;
    end else begin
      vsync_prev_q <= px.per_frame_vsync;
      href_prev_q  <= px.per_frame_href;
      col_q        <= col_d;
      row_q        <= row_d;
      ovf_q        <= ovf_d;
      fmode_q      <= fmode_d;
      sel_q        <= sel_d;
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_rd;
        win_q[1][2] <= lb1_rd;
        win_q[2][2] <= px.per_data;
      end
      for (int r = 0; r < 3; r++) begin
        s1_max_q[r] <= max3(win_q[r][0], win_q[r][1], win_q[r][2]);
        s1_mid_q[r] <= mid3(win_q[r][0], win_q[r][1], win_q[r][2]);
        s1_min_q[r] <= min3(win_q[r][0], win_q[r][1], win_q[r][2]);
      end
      s1_ctr_q  <= win_q[1][1];
      s1_sel_q  <= sel_q;
      s2_lo_q   <= max3(s1_min_q[0], s1_min_q[1], s1_min_q[2]);
      s2_md_q   <= mid3(s1_mid_q[0], s1_mid_q[1], s1_mid_q[2]);
      s2_hi_q   <= min3(s1_max_q[0], s1_max_q[1], s1_max_q[2]);
      s2_gmin_q <= min3(s1_min_q[0], s1_min_q[1], s1_min_q[2]);
      s2_gmax_q <= max3(s1_max_q[0], s1_max_q[1], s1_max_q[2]);
      s2_ctr_q  <= s1_ctr_q;
      s2_sel_q  <= s1_sel_q;
      case (s2_sel_q)
        2'd0:    data_q <= mid3(s2_lo_q, s2_md_q, s2_hi_q);
        2'd1:    data_q <= s2_gmin_q;
        2'd2:    data_q <= s2_gmax_q;
        default: data_q <= s2_ctr_q;
      endcase
      vs_dly_q <= {vs_dly_q[2:0], px.per_frame_vsync};
      hr_dly_q <= {hr_dly_q[2:0], px.per_frame_href};
      ck_dly_q <= {ck_dly_q[2:0], px.per_frame_clken};
    end
  end

  assign px.post_frame_vsync = vs_dly_q[3];
  assign px.post_frame_href  = hr_dly_q[3];
  assign px.post_frame_clken = ck_dly_q[3];
  assign px.post_data        = data_q;

endmodule

// File: tb/tb_rank_filter3x3.sv
// tb/tb_rank_filter3x3.sv - self-checking bench for rank_filter3x3
// Reference model sorts the nine window samples and picks the order statistic.
module tb_rank_filter3x3;
  localparam int DW = 8;
  localparam int H  = 8;
  localparam int V  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rank_filter3x3_if #(.DATA_W(DW)) bus ();

  rank_filter3x3 #(.DATA_W(DW), .IMG_HDISP(H), .IMG_VDISP(V), .CNT_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .px    (bus)
  );

  typedef struct {
    bit         vs, hr, ck;
    logic [7:0] data;
    bit         dk;
    bit         tg;
    logic [7:0] tv;
  } rec_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] p [9];
    logic [7:0] exp;
  } tv_t;

  rec_t q[$];
  int total = 0;
  int bad   = 0;

  int         m_col, m_row;
  bit         m_ovf, m_hr_prev, m_vs_prev;
  logic [1:0] m_fmode;
  logic [7:0] hist1 [H];
  logic [7:0] hist2 [H];
  bit         hk1 [H];
  bit         hk2 [H];
  logic [7:0] win [3][3];
  bit         wk  [3][3];
  logic [7:0] img [16][16];
  bit         next_tg;
  logic [7:0] next_tv;
  bit         tag_on;
  int         tag_r, tag_c;
  logic [7:0] tag_v;
  tv_t        tab [7];

  function automatic rec_t zrec();
    rec_t e;
    e.vs = 0; e.hr = 0; e.ck = 0; e.data = 8'd0; e.dk = 1; e.tg = 0; e.tv = 8'd0;
    return e;
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_ovf = 0; m_hr_prev = 0; m_vs_prev = 0; m_fmode = 2'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin win[r][c] = 8'd0; wk[r][c] = 1; end
  endtask

  task automatic model_step(input bit vs, input bit hr, input bit ck, input logic [7:0] d,
                            input logic [1:0] md);
    rec_t e; bit acc, vs_rise, hr_fall, cplt, allk; logic [1:0] sel; int vals[$];
    acc     = ck && hr && !m_ovf;
    vs_rise = vs && !m_vs_prev;
    hr_fall = !hr && m_hr_prev;
    cplt    = acc && (m_col >= 2) && (m_row >= 2);
    sel     = cplt ? m_fmode : 2'd3;
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] = win[r][1]; wk[r][0] = wk[r][1];
        win[r][1] = win[r][2]; wk[r][1] = wk[r][2];
      end
      win[0][2] = hist2[m_col]; wk[0][2] = hk2[m_col];
      win[1][2] = hist1[m_col]; wk[1][2] = hk1[m_col];
      win[2][2] = d;            wk[2][2] = 1;
      hist2[m_col] = hist1[m_col]; hk2[m_col] = hk1[m_col];
      hist1[m_col] = d;            hk1[m_col] = 1;
    end
    allk = 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin vals.push_back(int'(win[r][c])); allk &= wk[r][c]; end
    vals.sort();
    e.vs = vs; e.hr = hr; e.ck = ck;
    case (sel)
      2'd0:    begin e.data = 8'(vals[4]); e.dk = allk; end
      2'd1:    begin e.data = 8'(vals[0]); e.dk = allk; end
      2'd2:    begin e.data = 8'(vals[8]); e.dk = allk; end
      default: begin e.data = win[1][1];   e.dk = wk[1][1]; end
    endcase
    if (hr_fall) begin m_col = 0; m_ovf = 0; end
    else if (acc) begin
      if (m_col == H - 1) m_ovf = 1;
      else m_col++;
    end
    if (vs_rise) m_row = 0;
    else if (hr_fall && m_row < V - 1) m_row++;
    if (vs_rise) m_fmode = md;
    m_vs_prev = vs; m_hr_prev = hr;
    e.tg = next_tg; e.tv = next_tv; next_tg = 0;
    q.push_back(e);
  endtask

  task automatic check_outputs();
    rec_t e;
    if (q.size() < 4) return;
    e = q.pop_front();
    total++;
    if ({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken} !== {e.vs, e.hr, e.ck}) begin
      bad++;
      $display("FAIL sync_delay t=%0t got=%b want=%b", $time,
               {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken}, {e.vs, e.hr, e.ck});
    end
    if (e.dk) begin
      total++;
      if (bus.post_data !== e.data) begin
        bad++;
        $display("FAIL post_data t=%0t got=%h want=%h", $time, bus.post_data, e.data);
      end
    end
    if (e.tg) begin
      total++;
      if (bus.post_data !== e.tv) begin
        bad++;
        $display("FAIL table_vector t=%0t got=%h want=%h", $time, bus.post_data, e.tv);
      end
    end
  endtask

  task automatic cycle(input bit vs, input bit hr, input bit ck, input logic [7:0] d);
    check_outputs();
    bus.per_frame_vsync = vs;
    bus.per_frame_href  = hr;
    bus.per_frame_clken = ck;
    bus.per_data        = d;
    model_step(vs, hr, ck, d, bus.mode);
    @(negedge clk);
  endtask

  task automatic reset_pulse(input int ncyc);
    check_outputs();
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_data} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_data});
    end
    bus.per_frame_vsync = 0; bus.per_frame_href = 0; bus.per_frame_clken = 0; bus.per_data = 8'd0;
    model_reset();
    q = {zrec(), zrec(), zrec(), zrec()};
    @(negedge clk);
    for (int i = 0; i < ncyc; i++) begin
      check_outputs();
      q.push_back(zrec());
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic drive_frame(input int nl, input int np, input bit gaps, input int sw_line,
                             input logic [1:0] sw_mode);
    cycle(1, 0, 0, 8'd0); cycle(1, 0, 0, 8'd0);
    cycle(0, 0, 0, 8'd0); cycle(0, 0, 0, 8'd0);
    for (int r = 0; r < nl; r++) begin
      if (r == sw_line) bus.mode = sw_mode;
      for (int c = 0; c < np; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) cycle(0, 1, 0, 8'($urandom));
        if (tag_on && r == tag_r && c == tag_c) begin next_tg = 1; next_tv = tag_v; end
        cycle(0, 1, 1, img[r][c]);
      end
      cycle(0, 0, 0, 8'd0);
      cycle(0, 0, gaps, 8'($urandom));
      cycle(0, 0, 0, 8'd0);
    end
    cycle(0, 0, 0, 8'd0); cycle(0, 0, 0, 8'd0);
  endtask

  task automatic fill_img(input int kind, input logic [7:0] val);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img[r][c] = (kind == 0) ? val : 8'($urandom);
  endtask

  initial begin
    tab[0] = '{2'd0, '{8'd1, 8'd9, 8'd5, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd4}, 8'd5};
    tab[1] = '{2'd1, '{8'd1, 8'd9, 8'd5, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd4}, 8'd1};
    tab[2] = '{2'd2, '{8'd1, 8'd9, 8'd5, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd4}, 8'd9};
    tab[3] = '{2'd3, '{8'd1, 8'd9, 8'd5, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd4}, 8'd3};
    tab[4] = '{2'd0, '{8'd200, 8'd10, 8'd10, 8'd200, 8'd10, 8'd200, 8'd200, 8'd10, 8'd200}, 8'd200};
    tab[5] = '{2'd1, '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7}, 8'd7};
    tab[6] = '{2'd2, '{8'd3, 8'd3, 8'd250, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd250}, 8'd250};

    for (int c = 0; c < H; c++) begin hk1[c] = 0; hk2[c] = 0; hist1[c] = 8'd0; hist2[c] = 8'd0; end
    next_tg = 0; next_tv = 8'd0; tag_on = 0; tag_r = 0; tag_c = 0; tag_v = 8'd0;
    bus.per_frame_vsync = 0; bus.per_frame_href = 0; bus.per_frame_clken = 0;
    bus.per_data = 8'd0; bus.mode = 2'd0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_data} !== 11'd0) begin
      bad++;
      $display("FAIL initial_reset got=%h want=0",
               {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_data});
    end
    model_reset();
    q = {zrec(), zrec(), zrec(), zrec()};
    rst_n = 1'b1;

    // uniform field, twice so the line buffers hold known data
    bus.mode = 2'd0;
    fill_img(0, 8'h40);
    drive_frame(4, 8, 0, -1, 2'd0);
    drive_frame(4, 8, 0, -1, 2'd0);

    // single impulse in a flat field
    fill_img(0, 8'h10);
    img[2][3] = 8'hFF;
    drive_frame(5, 8, 0, -1, 2'd0);

    // table of hand-picked windows
    tag_on = 1; tag_r = 2; tag_c = 2;
    for (int i = 0; i < 7; i++) begin
      bus.mode = tab[i].mode;
      tag_v = tab[i].exp;
      for (int k = 0; k < 9; k++) img[k / 3][k % 3] = tab[i].p[k];
      drive_frame(3, 3, 0, -1, 2'd0);
    end
    tag_on = 0;

    // mode change mid-frame lands at the next frame
    bus.mode = 2'd0;
    fill_img(1, 8'd0);
    drive_frame(6, 8, 0, 3, 2'd2);
    fill_img(1, 8'd0);
    drive_frame(5, 8, 0, -1, 2'd0);

    // reset in the middle of a line, then a fresh frame
    bus.mode = 2'd0;
    fill_img(1, 8'd0);
    cycle(1, 0, 0, 8'd0); cycle(0, 0, 0, 8'd0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 2) ? 4 : 8); c++) cycle(0, 1, 1, img[r][c]);
      if (r < 2) begin cycle(0, 0, 0, 8'd0); cycle(0, 0, 0, 8'd0); end
    end
    reset_pulse(3);
    bus.mode = 2'd1;
    fill_img(1, 8'd0);
    drive_frame(5, 8, 1, -1, 2'd0);

    // randomized frames: gaps, overlong lines, extra lines
    for (int f = 0; f < 6; f++) begin
      bus.mode = 2'($urandom_range(0, 3));
      fill_img(1, 8'd0);
      drive_frame(int'($urandom_range(3, 10)), int'($urandom_range(5, 11)), 1, -1, 2'd0);
    end

    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rank_filter3x3.md
RANK_FILTER3X3 -- requirements
Module: rank_filter3x3

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel sample width in bits.
REQ-002 SHALL have parameter IMG_HDISP, default 1280, active pixels per line; sets line-buffer depth.
REQ-003 SHALL have parameter IMG_VDISP, default 720, active lines per frame.
REQ-004 SHALL have parameter CNT_W, default 11, width of the column and row counters.
REQ-005 SHALL have port clk, input, 1, pixel clock; the block uses only this clock.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port per_frame_vsync, input, 1, input frame sync.
REQ-008 SHALL have port per_frame_href, input, 1, input line valid.
REQ-009 SHALL have port per_frame_clken, input, 1, input pixel strobe.
REQ-010 SHALL have port per_data, input, DATA_W, input pixel.
REQ-011 SHALL have port mode, input, 2, filter select: 0 median, 1 min (erode), 2 max (dilate), 3 bypass.
REQ-012 SHALL have port post_frame_vsync, output, 1, delayed vsync.
REQ-013 SHALL have port post_frame_href, output, 1, delayed href.
REQ-014 SHALL have port post_frame_clken, output, 1, delayed pixel strobe.
REQ-015 SHALL have port post_data, output, DATA_W, filtered pixel.

Function
REQ-016 SHALL count columns: counter advances on clken with href high, clears on href falling edge, saturates at IMG_HDISP-1.
REQ-017 SHALL count lines: counter advances on href falling edge, clears on vsync rising edge, saturates at IMG_VDISP-1.
REQ-018 SHALL hold two line buffers of IMG_HDISP x DATA_W; each is written at the column address on clken with href high. Line 1 receives per_data. Line 2 receives the old line-1 word.
REQ-019 SHALL shift a 3x3 window on clken with href high. The new right column is {line2 word, line1 word, per_data}.
REQ-020 SHALL treat the window as complete only when the column count is >= 2 and the line count is >= 2.
REQ-021 SHALL output the window centre unfiltered when the window is incomplete, whatever the mode.
REQ-022 SHALL compute rank results over an unsigned, DATA_W-wide, free-running 3-stage pipeline.
REQ-023 SHALL, in stage 1, sort each window row into max/mid/min.
REQ-024 SHALL, in stage 2, form min-of-maxes, mid-of-mids, max-of-mins, global min and global max.
REQ-025 SHALL, in stage 3, select the result: median of the three stage-2 terms, global min, global max, or the centre pixel.
REQ-026 SHALL give equal values a deterministic order, so results equal the true order statistic.
REQ-027 SHALL sample mode into a frame-mode register on the vsync rising edge. A mode change mid-frame takes effect at the next frame only.
REQ-028 SHALL make total latency exactly 4 clk cycles from a clken sample to its post_data. Stages are: window capture, then 3 pipeline stages.
REQ-029 SHALL delay vsync, href and clken through 4-deep shift registers that advance every clk, so sync and data stay aligned.
REQ-030 SHALL ignore pixels beyond column IMG_HDISP-1: no buffer write, no window shift; their output is the unfiltered centre.
REQ-031 SHALL not shift the window or write the buffers on clken with href low.

Reset
REQ-032 SHALL, while rst_n is low, force these to 0: all post_* outputs, counters, window, pipeline, delay chains and frame-mode register.
REQ-033 SHALL not need line-buffer contents cleared; the incomplete-window rule hides stale data.
REQ-034 SHALL treat a reset mid-frame as frame start; the first two lines after release output the unfiltered centre.

Verification
REQ-035 SHALL check median on uniform data: 8x4 frame, IMG_HDISP=8, mode 0, all pixels 0x40 -> every post_data 0x40; post_frame_clken follows per_frame_clken 4 cycles later.
REQ-036 SHALL check impulse removal: mode 0, one pixel 0xFF in a 0x10 field at line 2, column 3 -> no post_data equals 0xFF for complete windows; all read 0x10.
REQ-037 SHALL check min/max: window rows {1,9,5},{7,3,8},{2,6,4} -> mode 0 gives 5, mode 1 gives 1, mode 2 gives 9, mode 3 gives 3.
REQ-038 SHALL check mode timing: mode changed 0 to 2 mid-frame -> output stays median until the next vsync rising edge, then becomes max.
REQ-039 SHALL check borders: lines 0-1 and columns 0-1 of each line -> post_data equals the window centre in all modes.
REQ-040 SHALL check reset: rst_n pulsed low mid-line -> all post_* outputs 0 at once; after release, counters restart and outputs match a fresh-frame model.
